i2c_slave_regs: RTL and testbench

//  I2C target (slave) that answers the team's I2C master on the same two-wire bus.

---
 rtl/i2c_slave_regs.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target serving a register file through a register-pointer protocol
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_REGS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_rd_addr,
  output logic [7:0] host_rd_data
);

  // Pointer width covers 0..NUM_REGS-1; NUM_REGS is 2..256 so this is 1..8 bits.
  localparam int              PW         = $clog2(NUM_REGS);
  localparam logic [8:0]      NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [PW-1:0]   LAST_IDX   = PW'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_REG,
    S_ACK_R,
    S_WDATA,
    S_ACK_W,
    S_RDATA,
    S_MACK,
    S_IDLE_WAIT
  } state_t;

  state_t        state;
  logic          scl_s1, scl_s2, scl_d;
  logic          sda_s1, sda_s2, sda_d;
  logic [7:0]    shift;
  logic [3:0]    bitcnt;
  logic          rw;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];

  logic          scl_rise, scl_fall;
  logic          start_det, stop_det;
  logic [7:0]    byte_in;
  logic          last_bit;
  logic [PW-1:0] ptr_next;

  // Two-stage synchronizers plus one delay stage; idle bus level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // Bus events derived from the synchronized levels. START/STOP need SCL
  // stable high across both samples so an SDA edge coinciding with an SCL
  // edge is not mistaken for a bus condition.
  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    byte_in   = {shift[6:0], sda_s2};
    last_bit  = (bitcnt == 4'd7);
    ptr_next  = (ptr == LAST_IDX) ? '0 : ptr + PW'(1);
  end

  // Protocol FSM: owns the register file, the pointer and all bus-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      shift     <= 8'h00;
      bitcnt    <= 4'd0;
      rw        <= 1'b0;
      ptr       <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        // START (or repeated START) takes priority over a simultaneous STOP.
        state  <= S_ADDR;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        bitcnt <= 4'd0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_REG, S_WDATA: begin
            if (scl_rise) begin
              shift  <= byte_in;
              bitcnt <= bitcnt + 4'd1;
              if (last_bit) begin
                bitcnt <= 4'd0;
                case (state)
                  S_ADDR: begin
                    if (byte_in[7:1] == SLAVE_ADDR) begin
                      state <= S_ACK_A;
                      busy  <= 1'b1;
                      rw    <= byte_in[0];
                    end else begin
                      // Not ours: stay silent until the next START.
                      state <= S_IDLE;
                    end
                  end
                  S_REG: begin
                    ptr   <= PW'({1'b0, byte_in} % NUM_REGS_W);
                    state <= S_ACK_R;
                  end
                  default: begin
                    regs[ptr] <= byte_in;
                    wr_strobe <= 1'b1;
                    wr_addr   <= 8'(ptr);
                    wr_data   <= byte_in;
                    ptr       <= ptr_next;
                    state     <= S_ACK_W;
                  end
                endcase
              end
            end
          end

          S_ACK_A, S_ACK_R, S_ACK_W: begin
            // First SCL fall pulls SDA low for the ACK, second one ends it.
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                bitcnt <= 4'd0;
                if (state == S_ACK_A && rw) begin
                  // Read: bit 7 goes out on this same fall.
                  state  <= S_RDATA;
                  sda_oe <= ~regs[ptr][7];
                  shift  <= {regs[ptr][6:0], 1'b0};
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == S_ACK_A) ? S_REG : S_WDATA;
                end
              end
            end
          end

          S_RDATA: begin
            // bitcnt counts SCL rises, i.e. bits the master has sampled.
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr_next;
                state  <= S_MACK;
              end else begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end

          S_MACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                state  <= S_RDATA;
                bitcnt <= 4'd0;
                shift  <= regs[ptr];
              end else begin
                state <= S_IDLE_WAIT;
              end
            end
          end

          S_IDLE, S_IDLE_WAIT: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Host read port: registered, so a same-cycle bus write yields the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_rd_data <= 8'h00;
    end else if ({1'b0, host_rd_addr} < NUM_REGS_W) begin
      host_rd_data <= regs[host_rd_addr[PW-1:0]];
    end else begin
      host_rd_data <= 8'h00;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - randomized bench for i2c_slave_regs against a register-map model
module tb_i2c_slave_regs;

  localparam int Q    = 5;
  localparam int NREG = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;
  logic [7:0] host_rd_addr = 8'h00;
  logic [7:0] host_rd_data;
  wire        sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .NUM_REGS(NREG)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_regs [NREG];
  int          model_ptr = 0;
  logic [15:0] strobe_q [$];
  logic [15:0] exp_q [$];
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];

  always @(negedge clk) if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q();
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~send_ack);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    host_rd_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = host_rd_data;
  endtask

  task automatic model_write(input logic [7:0] r, input int n);
    model_ptr = int'(r) % NREG;
    for (int i = 0; i < n; i++) begin
      model_regs[model_ptr] = wbuf[i];
      exp_q.push_back({8'(model_ptr), wbuf[i]});
      model_ptr = (model_ptr + 1) % NREG;
    end
  endtask

  function automatic logic [7:0] model_read();
    logic [7:0] v;
    v = model_regs[model_ptr];
    model_ptr = (model_ptr + 1) % NREG;
    return v;
  endfunction

  function automatic bit strobes_match();
    if (strobe_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (strobe_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // [addr+W][reg][wbuf[0..n-1]] STOP; returns the number of unacknowledged bytes.
  task automatic do_write(input logic [7:0] r, input int n, output int nacks);
    logic ack;
    nacks = 0;
    bus_start();
    write_byte(8'h84, ack); if (!ack) nacks++;
    write_byte(r, ack);     if (!ack) nacks++;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      if (!ack) nacks++;
    end
    bus_stop();
    model_write(r, n);
  endtask

  // [addr+R] then n bytes, master ACKs all but the last; oe_after is sampled after the NACK.
  task automatic do_read(input int n, output logic addr_ack, output logic oe_after);
    bus_start();
    write_byte(8'h85, addr_ack);
    for (int i = 0; i < n; i++) read_byte(i < n - 1, rbuf[i]);
    oe_after = sda_oe;
    bus_stop();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks += 6;
    if (sda_oe !== 1'b0)       begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (wr_strobe !== 1'b0)    begin errors++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
    if (wr_addr !== 8'h00)     begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
    if (wr_data !== 8'h00)     begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    if (host_rd_data !== 8'h00) begin errors++; $display("FAIL reset_host_rd_data got %h want 00", host_rd_data); end
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    for (int i = 0; i <= NREG; i++) begin
      host_read(i == NREG ? 8'd200 : 8'(i), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL reset_reg idx %0d got %h want 00", i, d); end
    end
  endtask

  task automatic test_write();
    logic ack;
    int   nacks;
    logic [7:0] d;
    nacks = 0;
    bus_start();
    write_byte(8'h84, ack); if (!ack) nacks++;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy); end
    write_byte(8'h03, ack); if (!ack) nacks++;
    write_byte(8'hA5, ack); if (!ack) nacks++;
    write_byte(8'h5A, ack); if (!ack) nacks++;
    bus_stop();
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    model_write(8'h03, 2);
    checks += 3;
    if (nacks !== 0) begin errors++; $display("FAIL write_acks got %0d nacks want 0", nacks); end
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
    if (!strobes_match()) begin errors++; $display("FAIL write_strobes got %0d events want %0d", strobe_q.size(), exp_q.size()); end
    strobe_q.delete(); exp_q.delete();
    host_read(8'h03, d);
    checks++;
    if (d !== model_regs[3]) begin errors++; $display("FAIL write_host_rd3 got %h want %h", d, model_regs[3]); end
    host_read(8'h04, d);
    checks++;
    if (d !== model_regs[4]) begin errors++; $display("FAIL write_host_rd4 got %h want %h", d, model_regs[4]); end
  endtask

  task automatic test_read();
    int   nacks;
    logic aack, oe_after;
    logic [7:0] e;
    do_write(8'h03, 0, nacks);
    do_read(2, aack, oe_after);
    checks += 3;
    if (nacks !== 0) begin errors++; $display("FAIL read_setptr got %0d nacks want 0", nacks); end
    if (aack !== 1'b1) begin errors++; $display("FAIL read_addr_ack got %b want 1", aack); end
    if (oe_after !== 1'b0) begin errors++; $display("FAIL read_release got sda_oe %b want 0", oe_after); end
    for (int i = 0; i < 2; i++) begin
      e = model_read();
      checks++;
      if (rbuf[i] !== e) begin errors++; $display("FAIL read_byte %0d got %h want %h", i, rbuf[i], e); end
    end
  endtask

  task automatic test_bad_addr();
    logic ack0, ack1;
    logic [7:0] a;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) a = 8'h90;
      else begin
        a = 8'($urandom_range(0, 255));
        if (a[7:1] == 7'h42) a = a ^ 8'h02;
      end
      bus_start();
      write_byte(a, ack0);
      write_byte(8'h01, ack1);
      checks += 3;
      if (ack0 !== 1'b0) begin errors++; $display("FAIL bad_addr_ack addr %h got ack want none", a); end
      if (ack1 !== 1'b0) begin errors++; $display("FAIL bad_addr_silent addr %h got ack want none", a); end
      if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy addr %h got %b want 0", a, busy); end
      bus_stop();
    end
    checks++;
    if (strobe_q.size() != 0) begin errors++; $display("FAIL bad_addr_strobes got %0d want 0", strobe_q.size()); end
    strobe_q.delete();
  endtask

  task automatic test_wrap();
    int nacks;
    logic [7:0] d;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'h0F, 2, nacks);
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(8'h23, 1, nacks);
    checks++;
    if (!strobes_match()) begin errors++; $display("FAIL wrap_strobes got %0d events want %0d", strobe_q.size(), exp_q.size()); end
    strobe_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      host_read(i == 0 ? 8'h0F : (i == 1 ? 8'h00 : 8'h03), d);
      checks++;
      if (d !== model_regs[i == 0 ? 15 : (i == 1 ? 0 : 3)]) begin
        errors++; $display("FAIL wrap_reg case %0d got %h want %h", i, d, model_regs[i == 0 ? 15 : (i == 1 ? 0 : 3)]);
      end
    end
  endtask

  task automatic test_repeated_start();
    int   nacks;
    logic a0, a1, a2;
    logic [7:0] d, e;
    wbuf[0] = 8'($urandom_range(1, 255));
    do_write(8'h02, 1, nacks);
    strobe_q.delete(); exp_q.delete();
    bus_start();
    write_byte(8'h84, a0);
    write_byte(8'h02, a1);
    bus_start();
    write_byte(8'h85, a2);
    read_byte(1'b0, d);
    bus_stop();
    model_ptr = 2;
    e = model_read();
    checks += 2;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rstart_acks got %b want 111", {a0, a1, a2}); end
    if (d !== e) begin errors++; $display("FAIL rstart_data got %h want %h", d, e); end
  endtask

  task automatic test_reset_mid();
    int   nacks;
    logic aack, b, oe_after;
    logic [7:0] d, e;
    wbuf[0] = 8'h00; wbuf[1] = 8'($urandom_range(1, 255));
    do_write(8'h06, 2, nacks);
    do_write(8'h06, 0, nacks);
    strobe_q.delete(); exp_q.delete();
    bus_start();
    write_byte(8'h85, aack);
    for (int i = 0; i < 4; i++) read_bit(b);
    sda_m = 1'b1;
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_driving got sda_oe %b want 1", sda_oe); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_release got sda_oe %b want 0", sda_oe); end
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
    bus_stop();
    host_read(8'h07, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mid_regs_cleared got %h want 00", d); end
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(8'h09, 1, nacks);
    do_write(8'h09, 0, nacks);
    do_read(1, aack, oe_after);
    e = model_read();
    checks += 2;
    if (!strobes_match()) begin errors++; $display("FAIL mid_after_strobes got %0d events want %0d", strobe_q.size(), exp_q.size()); end
    if (rbuf[0] !== e) begin errors++; $display("FAIL mid_after_read got %h want %h", rbuf[0], e); end
    strobe_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_traffic();
    int   nacks, n, m;
    logic aack, oe_after;
    logic [7:0] r, e;
    for (int it = 0; it < 6; it++) begin
      r = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(r, n, nacks);
      checks += 2;
      if (nacks !== 0) begin errors++; $display("FAIL rnd_write_acks it %0d got %0d nacks want 0", it, nacks); end
      if (!strobes_match()) begin errors++; $display("FAIL rnd_strobes it %0d got %0d events want %0d", it, strobe_q.size(), exp_q.size()); end
      strobe_q.delete(); exp_q.delete();
      do_write(r, 0, nacks);
      m = $urandom_range(1, 4);
      do_read(m, aack, oe_after);
      checks++;
      if (aack !== 1'b1) begin errors++; $display("FAIL rnd_read_ack it %0d got %b want 1", it, aack); end
      for (int i = 0; i < m; i++) begin
        e = model_read();
        checks++;
        if (rbuf[i] !== e) begin errors++; $display("FAIL rnd_read it %0d byte %0d got %h want %h", it, i, rbuf[i], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_repeated_start();
    test_reset_mid();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
